// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared types, sizes and byte-swap helper for the Huffman chunk codec
package huffman_pkg;

  localparam int CODE_MAX_LEN  = 16;
  localparam int CHUNK_MAX_LEN = 32;
  localparam int WORD_BITS     = 32;

  typedef logic [31:0] chunk_bits_t;
  typedef logic [4:0]  code_len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH_CHUNK,
    ST_FLUSH_WORD,
    ST_DONE
  } enc_state_t;

  // Stream bit 0 lands in the most significant byte lane seen by the decoder
  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/huffman_bit_packer.sv
// rtl/huffman_bit_packer.sv - LSB-first chunk accumulator and RAM word writer
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  emit,
  input  chunk_bits_t           chunk,
  input  logic [5:0]            chunk_len,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] RAM_address,
  output logic [31:0]           RAM_writedata,
  output logic                  RAM_write
);

  logic [63:0]           acc_q, acc_d;
  logic [5:0]            fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [63:0]           merged;
  logic [6:0]            total;
  logic [6:0]            total_m32;

  // Merge the chunk at the fill point and retire a full low word in the same step
  always_comb begin
    merged    = acc_q | ({32'b0, chunk} << fill_q);
    total     = {1'b0, fill_q} + {1'b0, chunk_len};
    total_m32 = total - 7'd32;
    acc_d     = acc_q;
    fill_d    = fill_q;
    addr_d    = addr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    if (clear) begin
      acc_d   = '0;
      fill_d  = '0;
      addr_d  = '0;
      waddr_d = '0;
      wdata_d = '0;
    end else if (emit) begin
      if (total >= 7'd32) begin
        wr_d    = 1'b1;
        wdata_d = byteswap32(merged[31:0]);
        waddr_d = addr_q;
        addr_d  = addr_q + 1'b1;
        acc_d   = merged >> 32;
        fill_d  = total_m32[5:0];
      end else begin
        acc_d  = merged;
        fill_d = total[5:0];
      end
    end else if (flush && (fill_q != 6'd0)) begin
      wr_d    = 1'b1;
      wdata_d = byteswap32(acc_q[31:0]);
      waddr_d = addr_q;
      addr_d  = addr_q + 1'b1;
      acc_d   = '0;
      fill_d  = '0;
    end
  end

  // Packer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      fill_q  <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  assign RAM_address   = waddr_q;
  assign RAM_writedata = wdata_q;
  assign RAM_write     = wr_q;

endmodule

// File: rtl/huffman_color_encoder.sv
// rtl/huffman_color_encoder.sv - colour to prefix code table, first code bit at bit 0
module huffman_color_encoder
  import huffman_pkg::*;
(
  input  logic [31:0] color,
  output chunk_bits_t code,
  output code_len_t   len,
  output logic        miss
);

  // Unknown colours fall back to the black entry and raise miss
  always_comb begin
    code = 32'h0;
    len  = 5'd1;
    miss = 1'b0;
    case (color)
      32'h0000_0000: begin code = 32'h00; len = 5'd1; end
      32'h00FF_FFFF: begin code = 32'h01; len = 5'd2; end
      32'h00FF_0000: begin code = 32'h03; len = 5'd3; end
      32'h0000_FF00: begin code = 32'h07; len = 5'd4; end
      32'h0000_00FF: begin code = 32'h0F; len = 5'd5; end
      32'h0080_8080: begin code = 32'h1F; len = 5'd6; end
      default:       miss = 1'b1;
    endcase
  end

endmodule

// File: rtl/huffman_length_encoder.sv
// rtl/huffman_length_encoder.sv - run length value to prefix code table (value 0 means 256)
module huffman_length_encoder
  import huffman_pkg::*;
(
  input  logic [7:0]  value,
  output chunk_bits_t code,
  output code_len_t   len
);

  // Short codes for 1, 2 and 256; everything else is escape 111 plus the raw 8-bit value
  always_comb begin
    code = {21'b0, value, 3'b111};
    len  = 5'd11;
    case (value)
      8'd1:    begin code = 32'h0; len = 5'd1; end
      8'd2:    begin code = 32'h1; len = 5'd2; end
      8'd0:    begin code = 32'h3; len = 5'd3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/huffman_chunk_encoder.sv
// rtl/huffman_chunk_encoder.sv - run-length + Huffman pixel encoder; HUFFMAN_ENC_STATS_EN adds chunk/word counters
module huffman_chunk_encoder
  import huffman_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_RUN    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic [31:0]           pixel_color,
  input  logic                  pixel_last,
  output logic                  pixel_ready,
  output logic [ADDR_WIDTH-1:0] RAM_address,
  output logic [31:0]           RAM_writedata,
  output logic                  RAM_write,
  output logic                  frame_done,
  output logic                  code_miss
`ifdef HUFFMAN_ENC_STATS_EN
  ,
  output logic [15:0]           chunk_count,
  output logic [ADDR_WIDTH-1:0] word_count
`endif
);

  enc_state_t  state_q, state_d;
  logic [31:0] run_color_q, run_color_d;
  logic [8:0]  run_len_q, run_len_d;
  logic        ready_q, ready_d;
  logic        frame_done_q, frame_done_d;
  logic        code_miss_q, code_miss_d;
  logic        xfer, emit, flush;
  chunk_bits_t cc, lcode, chunk;
  code_len_t   lc, ll;
  logic        c_miss;
  logic [5:0]  chunk_len;

  assign xfer = pixel_valid && ready_q;

  huffman_color_encoder u_color (
    .color (run_color_q),
    .code  (cc),
    .len   (lc),
    .miss  (c_miss)
  );

  huffman_length_encoder u_length (
    .value (run_len_q[7:0]),
    .code  (lcode),
    .len   (ll)
  );

  assign chunk     = cc | (lcode << lc);
  assign chunk_len = {1'b0, lc} + {1'b0, ll};

  huffman_bit_packer #(.ADDR_WIDTH(ADDR_WIDTH)) u_packer (
    .clk           (clk),
    .rst           (reset),
    .clear         (frame_start),
    .emit          (emit),
    .chunk         (chunk),
    .chunk_len     (chunk_len),
    .flush         (flush),
    .RAM_address   (RAM_address),
    .RAM_writedata (RAM_writedata),
    .RAM_write     (RAM_write)
  );

  // Run tracking and flush sequencing; the open run is always what gets emitted
  always_comb begin
    state_d      = state_q;
    run_color_d  = run_color_q;
    run_len_d    = run_len_q;
    emit         = 1'b0;
    flush        = 1'b0;
    frame_done_d = 1'b0;
    code_miss_d  = code_miss_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          run_color_d = pixel_color;
          run_len_d   = 9'd1;
          state_d     = pixel_last ? ST_FLUSH_CHUNK : ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if ((pixel_color == run_color_q) && (run_len_q < 9'(MAX_RUN))) begin
            run_len_d = run_len_q + 9'd1;
          end else begin
            emit        = 1'b1;
            run_color_d = pixel_color;
            run_len_d   = 9'd1;
          end
          if (pixel_last) state_d = ST_FLUSH_CHUNK;
        end
      end
      ST_FLUSH_CHUNK: begin
        emit    = 1'b1;
        state_d = ST_FLUSH_WORD;
      end
      ST_FLUSH_WORD: begin
        flush   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (emit && c_miss) code_miss_d = 1'b1;
    // Restart wins over everything, including an in-progress flush
    if (frame_start) begin
      state_d      = ST_IDLE;
      run_len_d    = 9'd0;
      emit         = 1'b0;
      flush        = 1'b0;
      frame_done_d = 1'b0;
      code_miss_d  = 1'b0;
    end
    ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      run_color_q  <= '0;
      run_len_q    <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      code_miss_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_color_q  <= run_color_d;
      run_len_q    <= run_len_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      code_miss_q  <= code_miss_d;
    end
  end

  assign pixel_ready = ready_q;
  assign frame_done  = frame_done_q;
  assign code_miss   = code_miss_q;

`ifdef HUFFMAN_ENC_STATS_EN
  logic [15:0]           chunk_cnt_q, chunk_cnt_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;

  // Saturating per-frame counters; nothing emits after DONE so they hold
  always_comb begin
    chunk_cnt_d = chunk_cnt_q;
    word_cnt_d  = word_cnt_q;
    if (frame_start) begin
      chunk_cnt_d = '0;
      word_cnt_d  = '0;
    end else begin
      if (emit && (chunk_cnt_q != '1)) chunk_cnt_d = chunk_cnt_q + 1'b1;
      if (RAM_write && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chunk_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      chunk_cnt_q <= chunk_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign chunk_count = chunk_cnt_q;
  assign word_count  = word_cnt_q;
`endif

endmodule

// File: tb/tb_huffman_chunk_encoder.sv
// tb/tb_huffman_chunk_encoder.sv - randomized bench with a bit-queue reference model
module tb_huffman_chunk_encoder;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          pixel_valid;
  logic [31:0]   pixel_color;
  logic          pixel_last;
  logic          pixel_ready;
  logic [AW-1:0] RAM_address;
  logic [31:0]   RAM_writedata;
  logic          RAM_write;
  logic          frame_done;
  logic          code_miss;
`ifdef HUFFMAN_ENC_STATS_EN
  logic [15:0]   chunk_count;
  logic [AW-1:0] word_count;
`endif

  always #5 clk = ~clk;

  huffman_chunk_encoder #(.ADDR_WIDTH(AW), .MAX_RUN(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .pixel_valid   (pixel_valid),
    .pixel_color   (pixel_color),
    .pixel_last    (pixel_last),
    .pixel_ready   (pixel_ready),
    .RAM_address   (RAM_address),
    .RAM_writedata (RAM_writedata),
    .RAM_write     (RAM_write),
    .frame_done    (frame_done),
    .code_miss     (code_miss)
`ifdef HUFFMAN_ENC_STATS_EN
    ,
    .chunk_count   (chunk_count),
    .word_count    (word_count)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM write capture and frame_done pulse counting
  logic [31:0] cap_data[$];
  int          cap_addr[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (RAM_write) begin
      cap_data.push_back(RAM_writedata);
      cap_addr.push_back(int'(RAM_address));
    end
    if (frame_done) done_cnt++;
  end

  // Reference: code table, run splitting, bit stream and word packing
  logic [31:0] pal [6] = '{32'h0000_0000, 32'h00FF_FFFF, 32'h00FF_0000,
                           32'h0000_FF00, 32'h0000_00FF, 32'h0080_8080};
  logic [31:0] pix_q[$];
  bit          bits_q[$];
  logic [31:0] exp_w[$];
  int          exp_chunks;
  bit          exp_miss;

  function automatic int pal_idx(input logic [31:0] c);
    for (int k = 0; k < 6; k++) if (pal[k] == c) return k;
    return -1;
  endfunction

  task automatic add_chunk(input logic [31:0] c, input int n);
    int idx;
    idx = pal_idx(c);
    if (idx < 0) begin
      exp_miss = 1'b1;
      idx = 0;
    end
    // colour i is i ones then a zero
    for (int k = 0; k < idx; k++) bits_q.push_back(1'b1);
    bits_q.push_back(1'b0);
    if (n == 1) begin
      bits_q.push_back(1'b0);
    end else if (n == 2) begin
      bits_q.push_back(1'b1); bits_q.push_back(1'b0);
    end else if (n == 256) begin
      bits_q.push_back(1'b1); bits_q.push_back(1'b1); bits_q.push_back(1'b0);
    end else begin
      bits_q.push_back(1'b1); bits_q.push_back(1'b1); bits_q.push_back(1'b1);
      for (int k = 0; k < 8; k++) bits_q.push_back(bit'((n >> k) & 1));
    end
    exp_chunks++;
  endtask

  task automatic build_model();
    int i;
    int n;
    int nw;
    logic [31:0] s;
    bits_q.delete();
    exp_w.delete();
    exp_chunks = 0;
    exp_miss = 1'b0;
    i = 0;
    while (i < pix_q.size()) begin
      n = 1;
      while ((i + n < pix_q.size()) && (pix_q[i+n] == pix_q[i]) && (n < 256)) n++;
      add_chunk(pix_q[i], n);
      i += n;
    end
    nw = (bits_q.size() + 31) / 32;
    for (int w = 0; w < nw; w++) begin
      s = '0;
      for (int k = 0; k < 32; k++)
        if (32 * w + k < bits_q.size()) s[k] = bits_q[32*w+k];
      exp_w.push_back({s[7:0], s[15:8], s[23:16], s[31:24]});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cap_data.delete();
    cap_addr.delete();
    check_eq("start_no_write", RAM_write, 1'b0);
  endtask

  task automatic run_frame(input string name, input bit do_start);
    int d0;
    int t;
    int nc;
    if (do_start) pulse_start();
    build_model();
    d0 = done_cnt;
    for (int i = 0; i < pix_q.size(); i++) begin
      @(negedge clk);
      t = 0;
      while (!pixel_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!pixel_ready) check_eq({name, "_ready"}, pixel_ready, 1'b1);
      pixel_valid = 1'b1;
      pixel_color = pix_q[i];
      pixel_last  = (i == pix_q.size() - 1);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    pixel_last  = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_eq({name, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({name, "_word_count"}, cap_data.size(), exp_w.size());
    nc = (cap_data.size() < exp_w.size()) ? cap_data.size() : exp_w.size();
    for (int i = 0; i < nc; i++) begin
      check_eq({name, "_word_data"}, cap_data[i], exp_w[i]);
      check_eq({name, "_word_addr"}, cap_addr[i], i);
    end
    check_eq({name, "_code_miss"}, code_miss, exp_miss);
    check_eq({name, "_ready_after"}, pixel_ready, 1'b1);
`ifdef HUFFMAN_ENC_STATS_EN
    check_eq({name, "_chunk_count"}, chunk_count, exp_chunks);
    check_eq({name, "_word_count_port"}, word_count, exp_w.size());
`endif
  endtask

  task automatic add_run(input logic [31:0] c, input int n);
    for (int k = 0; k < n; k++) pix_q.push_back(c);
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_color = '0;
    pixel_last  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ready", pixel_ready, 1'b0);
    check_eq("rst_write", RAM_write, 1'b0);
    check_eq("rst_addr", RAM_address, 0);
    check_eq("rst_data", RAM_writedata, 0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_miss", code_miss, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", pixel_ready, 1'b1);
    check_eq("post_rst_write", RAM_write, 1'b0);

    // 300 identical pixels: runs 256 and 44
    pix_q.delete();
    add_run(pal[1], 300);
    run_frame("long_run", 1'b1);
    check_eq("long_run_chunks", exp_chunks, 2);

    // alternating colours: 64 single-pixel chunks, exact word boundary at the end
    pix_q.delete();
    for (int i = 0; i < 64; i++) pix_q.push_back(i[0] ? pal[3] : pal[2]);
    run_frame("alternate", 1'b1);

    // random runs of table colours
    for (int f = 0; f < 5; f++) begin
      pix_q.delete();
      for (int r = 0; r < 2 + f * 2; r++)
        add_run(pal[$urandom_range(0, 5)], $urandom_range(1, 300));
      run_frame("random", 1'b1);
    end

    // restart mid-run with a valid pixel present
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_color = pal[$urandom_range(0, 5)];
      pixel_last  = 1'b0;
    end
    @(negedge clk);
    frame_start = 1'b1;
    pixel_color = pal[5];
    @(negedge clk);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    check_eq("midrun_no_write", RAM_write, 1'b0);
    check_eq("midrun_miss", code_miss, 1'b0);
    cap_data.delete();
    cap_addr.delete();
    pix_q.delete();
    add_run(pal[4], 3);
    add_run(pal[0], 70);
    add_run(pal[4], 1);
    run_frame("after_restart", 1'b0);

    // colour missing from the table
    pix_q.delete();
    add_run(pal[0], 4);
    add_run(32'h1234_5678, 5);
    add_run(pal[2], 2);
    run_frame("code_miss", 1'b1);
    repeat (4) @(negedge clk);
    check_eq("miss_sticky", code_miss, 1'b1);
    pulse_start();
    check_eq("miss_cleared", code_miss, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
